// File: rtl/vga_display_data_bank.sv
// Display data store for the VGA pointer path. Optional shadow bank (VGA_SHADOW_BUFFER_EN) refreshed at VSync start.
// Latency: read data 1 clk after MemAddrIN; WrAck 1 clk after acceptance; shadow refresh takes 2**AW clks.
// Backpressure: WrReq is held by the producer; it is not accepted while WrAck is high or while the copy runs.
module vga_display_data_bank #(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          WrReq,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] WrData,
    output logic          WrAck,
    input  logic [AW-1:0] MemAddrIN,
    output logic [DW-1:0] MemDataOut,
    input  logic          VSync,
    output logic          Busy,
    output logic          CopyDone
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] working [DEPTH];
    logic          wr_accept;

`ifdef VGA_SHADOW_BUFFER_EN

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic          vsync_q;
    logic          vsync_start;
    logic          last_idx;
    logic [DW-1:0] shadow [DEPTH];

    // Only the inactive-to-active transition starts a refresh; a held level does not.
    assign vsync_start = (VSync == VSYNC_POL) && (vsync_q != VSYNC_POL);
    assign last_idx    = (idx == AW'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_accept = 1'b0;
        Busy      = 1'b0;
        CopyDone  = 1'b0;
        case (state)
            IDLE: begin
                wr_accept = WrReq && !WrAck;
                if (vsync_start) begin
                    state_nxt = COPY;
                end
            end
            COPY: begin
                Busy    = 1'b1;
                idx_nxt = idx + AW'(1);
                if (last_idx) begin
                    CopyDone  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            idx        <= '0;
            vsync_q    <= ~VSYNC_POL;
            WrAck      <= 1'b0;
            MemDataOut <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                working[i] <= '0;
                shadow[i]  <= '0;
            end
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            vsync_q    <= VSync;
            WrAck      <= wr_accept;
            MemDataOut <= shadow[MemAddrIN];
            if (wr_accept) begin
                working[WrAddr] <= WrData;
            end
            // Writes are locked out during COPY, so working is stable for the whole copy.
            if (state == COPY) begin
                shadow[idx] <= working[idx];
            end
        end
    end

`else

    logic unused_vsync;

    assign unused_vsync = VSync;
    assign wr_accept    = WrReq && !WrAck;
    assign Busy         = 1'b0;
    assign CopyDone     = 1'b0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            WrAck      <= 1'b0;
            MemDataOut <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                working[i] <= '0;
            end
        end else begin
            WrAck      <= wr_accept;
            MemDataOut <= working[MemAddrIN];
            if (wr_accept) begin
                working[WrAddr] <= WrData;
            end
        end
    end

`endif

endmodule

// File: tb/tb_vga_display_data_bank.sv
// Scoreboard bench for vga_display_data_bank; covers both the single-bank and shadow-bank builds.
module tb_vga_display_data_bank;

    logic       CLK;
    logic       RESET;
    logic       WrReq;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       WrAck;
    logic [3:0] MemAddrIN;
    logic [7:0] MemDataOut;
    logic       VSync;
    logic       Busy;
    logic       CopyDone;

    int errors = 0;
    int checks = 0;
    int busy_cyc = 0;
    int done_cnt = 0;

    logic [7:0] model_work   [16];
    logic [7:0] model_shadow [16];
    logic [7:0] exp_q [$];

    vga_display_data_bank #(.AW(4), .DW(8), .VSYNC_POL(1'b0)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WrReq      (WrReq),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .WrAck      (WrAck),
        .MemAddrIN  (MemAddrIN),
        .MemDataOut (MemDataOut),
        .VSync      (VSync),
        .Busy       (Busy),
        .CopyDone   (CopyDone)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Busy)     busy_cyc++;
        if (CopyDone) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [3:0] a);
`ifdef VGA_SHADOW_BUFFER_EN
        return model_shadow[a];
`else
        return model_work[a];
`endif
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            model_work[i]   = 8'h00;
            model_shadow[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        WrReq = 1'b0;
        VSync = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_wrack", WrAck, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_copydone", CopyDone, 0);
        chk("rst_memdata", MemDataOut, 0);
        RESET = 1'b0;
        clear_models();
    endtask

    // Tasks are entered and left just after a falling edge.
    task automatic rd_range(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] a;
            a = 4'(first + i);
            MemAddrIN = a;
            exp_q.push_back(exp_rd(a));
            @(negedge CLK);
            chk($sformatf("rd[%0d]", a), MemDataOut, exp_q.pop_front());
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, output int lat, output logic busy_at_ack);
        WrReq  = 1'b1;
        WrAddr = a;
        WrData = d;
        lat    = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!WrAck && lat < 64);
        if (!WrAck) chk("ack_timeout", WrAck, 1);
        busy_at_ack = Busy;
        WrReq = 1'b0;
        model_work[a] = d;
        @(negedge CLK);
        chk($sformatf("ack_pulse[%0d]", a), WrAck, 0);
    endtask

    task automatic copy_wait(input string tag, input int b0, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        chk({tag, "_busy_cycles"}, busy_cyc - b0, 16);
        chk({tag, "_copydone"}, done_cnt - d0, 1);
    endtask

    task automatic copy_frame(input string tag);
        int b0, d0;
        b0 = busy_cyc;
        d0 = done_cnt;
        model_shadow = model_work;
        VSync = 1'b0;
        repeat (3) @(negedge CLK);
        VSync = 1'b1;
        copy_wait(tag, b0, d0);
    endtask

    initial begin
        int   lat;
        logic bsy;
        CLK       = 1'b0;
        RESET     = 1'b1;
        WrReq     = 1'b0;
        WrAddr    = '0;
        WrData    = '0;
        MemAddrIN = '0;
        VSync     = 1'b1;
        clear_models();
        @(negedge CLK);

        do_reset();
        rd_range(0, 16);

        wr(4'd3, 8'h5A, lat, bsy);
        chk("wr3_lat", lat, 1);
        rd_range(3, 1);

`ifdef VGA_SHADOW_BUFFER_EN
        copy_frame("t2");
        rd_range(3, 1);

        begin
            int b0, d0, n;
            b0 = busy_cyc;
            d0 = done_cnt;
            model_shadow = model_work;
            VSync = 1'b0;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!Busy && n < 10);
            chk("t3_busy_seen", Busy, 1);
            VSync = 1'b1;
            @(negedge CLK);
            VSync = 1'b0;
            @(negedge CLK);
            wr(4'd7, 8'hC3, lat, bsy);
            chk("t3_ack_lat", lat, 15);
            chk("t3_busy_at_ack", bsy, 0);
            VSync = 1'b1;
            repeat (2) @(negedge CLK);
            chk("t3_busy_cycles", busy_cyc - b0, 16);
            chk("t3_copydone", done_cnt - d0, 1);
        end
        rd_range(7, 1);
        copy_frame("t3b");
        rd_range(7, 1);

        begin
            int b0, d0;
            b0 = busy_cyc;
            d0 = done_cnt;
            VSync = 1'b0;
            wr(4'd0, 8'h11, lat, bsy);
            chk("t4_ack_lat", lat, 1);
            VSync = 1'b1;
            model_shadow = model_work;
            copy_wait("t4", b0, d0);
        end
        rd_range(0, 1);

        begin
            int d0, n;
            VSync = 1'b0;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!Busy && n < 10);
            repeat (8) @(negedge CLK);
            d0 = done_cnt;
            RESET = 1'b1;
            @(negedge CLK);
            chk("t5_busy_in_rst", Busy, 0);
            chk("t5_wrack_in_rst", WrAck, 0);
            @(negedge CLK);
            RESET = 1'b0;
            VSync = 1'b1;
            clear_models();
            repeat (20) @(negedge CLK);
            chk("t5_no_copydone", done_cnt - d0, 0);
            chk("t5_busy_idle", Busy, 0);
        end
        rd_range(0, 16);
        wr(4'd9, 8'h3C, lat, bsy);
        chk("t5_wr_lat", lat, 1);
        copy_frame("t5");
        rd_range(0, 16);
`else
        wr(4'd5, 8'hA5, lat, bsy);
        chk("wr5_lat", lat, 1);
        rd_range(5, 1);
        wr(4'd0, 8'hFF, lat, bsy);
        wr(4'd15, 8'h01, lat, bsy);
        rd_range(15, 2);
        repeat (3) begin
            VSync = 1'b0;
            repeat (4) @(negedge CLK);
            VSync = 1'b1;
            repeat (4) @(negedge CLK);
        end
        rd_range(0, 16);
`endif

        begin
            int acks;
            acks = 0;
            WrReq  = 1'b1;
            WrAddr = 4'd9;
            WrData = 8'h3C;
            repeat (4) begin
                @(negedge CLK);
                if (WrAck) acks++;
            end
            WrReq = 1'b0;
            model_work[9] = 8'h3C;
            @(negedge CLK);
            chk("held_req_acks", acks, 2);
        end

        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 8'($urandom_range(0, 255)), lat, bsy);
            chk($sformatf("rand_lat[%0d]", i), lat, 1);
        end
`ifdef VGA_SHADOW_BUFFER_EN
        rd_range(0, 16);
        copy_frame("rand");
`else
        chk("busy_never", busy_cyc, 0);
        chk("copydone_never", done_cnt, 0);
`endif
        rd_range(0, 16);

        do_reset();
        rd_range(0, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
